// File: rtl/noc_pkg.sv
// Shared NoC definitions: port enumeration, route-mode encodings and the
// dimension-order route function.
//   N_PORTS  : number of router ports (L, W, N, E, S)
//   PIDX_W   : width of a port / input index
//   xy_route : output port for a destination, given router coordinates
package noc_pkg;

  localparam int unsigned N_PORTS  = 5;
  localparam int unsigned PIDX_W   = 3;
  localparam int unsigned ROUTE_XY = 0;
  localparam int unsigned ROUTE_YX = 1;

  typedef enum logic [PIDX_W-1:0] {
    PORT_L = 3'd0,
    PORT_W = 3'd1,
    PORT_N = 3'd2,
    PORT_E = 3'd3,
    PORT_S = 3'd4
  } port_e;

  // Dimension-order route; N is the smaller-y direction.
  // Range checking of the destination is left to the caller.
  function automatic port_e xy_route(input int unsigned dx, input int unsigned dy,
                                     input int unsigned rx, input int unsigned ry,
                                     input int unsigned mode);
    port_e x_port;
    port_e y_port;
    port_e p;
    x_port = (dx < rx) ? PORT_W : ((dx > rx) ? PORT_E : PORT_L);
    y_port = (dy < ry) ? PORT_N : ((dy > ry) ? PORT_S : PORT_L);
    if (mode == ROUTE_YX) p = (y_port != PORT_L) ? y_port : x_port;
    else                  p = (x_port != PORT_L) ? x_port : y_port;
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Five-request round-robin arbiter with a registered priority pointer.
//   clk, rst   : clock, synchronous active-high reset
//   req        : request per input
//   accept     : pick is taken this cycle; pointer moves past the winner
//   gnt_vld_c  : some request is present (combinational)
//   gnt_idx_c  : index of the winning input (combinational)
module rr_arbiter
  import noc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic               accept,
  output logic               gnt_vld_c,
  output logic [PIDX_W-1:0]  gnt_idx_c
);

  localparam int unsigned SUM_W = PIDX_W + 1;

  logic [PIDX_W-1:0] ptr_q, ptr_d;
  logic [SUM_W-1:0]  sum_c;
  logic [PIDX_W-1:0] idx_c;

  // First requester found scanning upward (mod N_PORTS) from the pointer.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    sum_c     = '0;
    idx_c     = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      sum_c = SUM_W'(ptr_q) + SUM_W'(k);
      idx_c = (sum_c >= SUM_W'(N_PORTS)) ? PIDX_W'(sum_c - SUM_W'(N_PORTS)) : PIDX_W'(sum_c);
      if (!gnt_vld_c && req[idx_c]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = idx_c;
      end
    end
  end

  // Winner's successor becomes highest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && gnt_vld_c) begin
      ptr_d = (gnt_idx_c == PIDX_W'(N_PORTS - 1)) ? '0 : gnt_idx_c + PIDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/route_alloc_unit.sv
// Route computation and per-output wormhole allocation for a 5-port router.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : flit present on input i
//   in_head    : flit on input i is a head flit
//   in_tail    : flit on input i is a tail flit
//   in_dest    : destination {y,x}, looked at only while a head waits
//   out_ready  : downstream of output o can accept
//   in_grant   : flit on input i transfers this cycle
//   out_valid  : output o carries a flit this cycle
//   out_src    : input currently owning output o
//   route_err  : one-cycle pulse when an out-of-range destination is allocated
module route_alloc_unit
  import noc_pkg::*;
#(
  parameter  int unsigned NOC_WIDTH  = 4,
  parameter  int unsigned NOC_LENGTH = 4,
  parameter  int unsigned ROUTER_ID  = 4'b1001,
  parameter  int unsigned ROUTE_MODE = ROUTE_XY,
  localparam int unsigned X_W        = $clog2(NOC_WIDTH),
  localparam int unsigned Y_W        = $clog2(NOC_LENGTH),
  localparam int unsigned ADDR_W     = X_W + Y_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_PORTS-1:0]                in_valid,
  input  logic [N_PORTS-1:0]                in_head,
  input  logic [N_PORTS-1:0]                in_tail,
  input  logic [N_PORTS-1:0][ADDR_W-1:0]    in_dest,
  input  logic [N_PORTS-1:0]                out_ready,
  output logic [N_PORTS-1:0]                in_grant,
  output logic [N_PORTS-1:0]                out_valid,
  output logic [N_PORTS-1:0][PIDX_W-1:0]    out_src,
  output logic                              route_err
);

  localparam int unsigned RX = ROUTER_ID % (2 ** X_W);
  localparam int unsigned RY = (ROUTER_ID >> X_W) % (2 ** Y_W);

  logic [N_PORTS-1:0]               lock_q,  lock_d;
  logic [N_PORTS-1:0][PIDX_W-1:0]   owner_q, owner_d;
  logic [N_PORTS-1:0][PIDX_W-1:0]   route_q, route_d;
  logic                             err_q,   err_d;

  logic [N_PORTS-1:0][PIDX_W-1:0]   want_c;
  logic [N_PORTS-1:0]               oob_c;
  logic [N_PORTS-1:0]               locked_c;
  logic [N_PORTS-1:0][N_PORTS-1:0]  req_c;    // [output][input]
  logic [N_PORTS-1:0]               gv_c;
  logic [N_PORTS-1:0][PIDX_W-1:0]   gi_c;
  int unsigned                      dx_c, dy_c;

  // Route each input's head and raise its request if it owns no output.
  always_comb begin : route_req
    want_c   = '0;
    oob_c    = '0;
    locked_c = '0;
    req_c    = '0;
    dx_c     = '0;
    dy_c     = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      dx_c        = 32'(in_dest[i][X_W-1:0]);
      dy_c        = 32'(in_dest[i][ADDR_W-1:X_W]);
      oob_c[i]    = (dx_c >= NOC_WIDTH) || (dy_c >= NOC_LENGTH);
      want_c[i]   = oob_c[i] ? PORT_L : xy_route(dx_c, dy_c, RX, RY, ROUTE_MODE);
      locked_c[i] = lock_q[route_q[i]] && (owner_q[route_q[i]] == PIDX_W'(i));
      if (in_valid[i] && in_head[i] && !locked_c[i]) req_c[want_c[i]][i] = 1'b1;
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_c[o]),
      .accept    (!lock_q[o]),
      .gnt_vld_c (gv_c[o]),
      .gnt_idx_c (gi_c[o])
    );
  end

  // Transfer outputs straight from the lock state; forced idle during reset.
  always_comb begin : xfer
    in_grant  = '0;
    out_valid = '0;
    out_src   = '0;
    route_err = 1'b0;
    if (!rst) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        in_grant[i] = in_valid[i] && locked_c[i] && out_ready[route_q[i]];
      end
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        out_valid[o] = lock_q[o] && in_valid[owner_q[o]];
        out_src[o]   = owner_q[o];
      end
      route_err = err_q;
    end
  end

  // Tail releases; free outputs take their arbiter's pick.
  always_comb begin : nxt
    lock_d  = lock_q;
    owner_d = owner_q;
    route_d = route_q;
    err_d   = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (in_grant[i] && in_tail[i]) lock_d[route_q[i]] = 1'b0;
    end
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      if (!lock_q[o] && gv_c[o]) begin
        lock_d[o]          = 1'b1;
        owner_d[o]         = gi_c[o];
        route_d[gi_c[o]]   = PIDX_W'(o);
        err_d              = err_d | oob_c[gi_c[o]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= '0;
      owner_q <= '0;
      route_q <= '0;
      err_q   <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      route_q <= route_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_route_alloc_unit.sv
// Bench for route_alloc_unit: three instances (XY 4x4, YX 4x4, XY 3-wide),
// directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a packet-level model.
module tb_route_alloc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic rst_req = 1'b1;

  logic [4:0]      v[3], h[3], t[3], rdy[3], g[3], ov[3];
  logic [4:0][3:0] d[3];
  logic [4:0][2:0] src[3];
  logic            err[3];

  route_alloc_unit #(.NOC_WIDTH(4), .NOC_LENGTH(4), .ROUTER_ID(9), .ROUTE_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in_head(h[0]), .in_tail(t[0]), .in_dest(d[0]),
    .out_ready(rdy[0]), .in_grant(g[0]), .out_valid(ov[0]), .out_src(src[0]), .route_err(err[0]));
  route_alloc_unit #(.NOC_WIDTH(4), .NOC_LENGTH(4), .ROUTER_ID(9), .ROUTE_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in_head(h[1]), .in_tail(t[1]), .in_dest(d[1]),
    .out_ready(rdy[1]), .in_grant(g[1]), .out_valid(ov[1]), .out_src(src[1]), .route_err(err[1]));
  route_alloc_unit #(.NOC_WIDTH(3), .NOC_LENGTH(4), .ROUTER_ID(9), .ROUTE_MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v[2]), .in_head(h[2]), .in_tail(t[2]), .in_dest(d[2]),
    .out_ready(rdy[2]), .in_grant(g[2]), .out_valid(ov[2]), .out_src(src[2]), .route_err(err[2]));

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference route: router at x=1,y=2; instance 1 is YX, instance 2 is 3 wide.
  function automatic int m_route(input int k, input logic [3:0] dest);
    int dx, dy, w;
    dx = int'(dest) % 4;
    dy = int'(dest) / 4;
    w  = (k == 2) ? 3 : 4;
    if (dx >= w) return 0;
    if (k == 1) begin
      if (dy < 2) return 2;
      if (dy > 2) return 4;
      if (dx < 1) return 1;
      if (dx > 1) return 3;
      return 0;
    end
    if (dx < 1) return 1;
    if (dx > 1) return 3;
    if (dy < 2) return 2;
    if (dy > 2) return 4;
    return 0;
  endfunction

  function automatic bit m_oob(input int k, input logic [3:0] dest);
    return (int'(dest) % 4) >= ((k == 2) ? 3 : 4);
  endfunction

  // ---------------- stimulus driver ----------------
  int   q_dest[3][5][$];
  int   q_len[3][5][$];
  bit   act[3][5];
  int   c_len[3][5], c_idx[3][5], c_dest[3][5];
  logic [4:0] exp_g[3];
  int   bubble_pct = 0;
  int   ready_pct = 100;
  bit   rand_mode = 1'b0;
  bit   force_low[3][5];
  bit   show_b;

  always @(posedge clk) begin
    #1;
    rst = rst_req;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (rst_req) begin
          act[k][i] = 1'b0;
          q_dest[k][i].delete();
          q_len[k][i].delete();
        end else begin
          if (act[k][i] && exp_g[k][i]) begin
            c_idx[k][i]++;
            if (c_idx[k][i] == c_len[k][i]) act[k][i] = 1'b0;
          end
          if (!act[k][i] && rand_mode && q_dest[k][i].size() == 0 && $urandom_range(99) < 30) begin
            q_dest[k][i].push_back(int'($urandom_range(15)));
            q_len[k][i].push_back(int'($urandom_range(4, 1)));
          end
          if (!act[k][i] && q_dest[k][i].size() > 0) begin
            c_dest[k][i] = q_dest[k][i].pop_front();
            c_len[k][i]  = q_len[k][i].pop_front();
            c_idx[k][i]  = 0;
            act[k][i]    = 1'b1;
          end
        end
        show_b  = act[k][i] && (int'($urandom_range(99)) >= bubble_pct);
        v[k][i] = show_b;
        h[k][i] = show_b && (c_idx[k][i] == 0);
        t[k][i] = show_b && (c_idx[k][i] == c_len[k][i] - 1);
        d[k][i] = act[k][i] ? 4'(c_dest[k][i]) : 4'($urandom_range(15));
      end
      for (int o = 0; o < 5; o++) begin
        rdy[k][o] = !force_low[k][o] && (int'($urandom_range(99)) < ready_pct);
      end
    end
  end

  // ---------------- model + per-cycle compare ----------------
  int   own[3][5], last[3][5], ptr[3][5];
  bit   errp[3];
  int   lo[5], nown[5];
  int   cand;
  bit   nerr, done_b;
  logic [4:0] eg, ev;
  logic [4:0][2:0] es;
  logic ee;

  always @(negedge clk) begin
    cyc_n++;
    for (int k = 0; k < 3; k++) begin
      eg = '0; ev = '0; es = '0; ee = 1'b0;
      if (!rst) begin
        for (int i = 0; i < 5; i++) begin
          lo[i] = -1;
          for (int o = 0; o < 5; o++) if (own[k][o] == i) lo[i] = o;
        end
        for (int o = 0; o < 5; o++) begin
          if (own[k][o] >= 0) ev[o] = v[k][own[k][o]];
          es[o] = 3'(last[k][o]);
        end
        for (int i = 0; i < 5; i++) begin
          if (lo[i] >= 0) eg[i] = v[k][i] && rdy[k][lo[i]];
        end
        ee = errp[k];
      end
      chk($sformatf("dut%0d cyc%0d in_grant", k, cyc_n), 32'(g[k]), 32'(eg));
      chk($sformatf("dut%0d cyc%0d out_valid", k, cyc_n), 32'(ov[k]), 32'(ev));
      chk($sformatf("dut%0d cyc%0d out_src", k, cyc_n), 32'(src[k]), 32'(es));
      chk($sformatf("dut%0d cyc%0d route_err", k, cyc_n), 32'(err[k]), 32'(ee));
      exp_g[k] = eg;
      if (rst) begin
        for (int o = 0; o < 5; o++) begin own[k][o] = -1; last[k][o] = 0; ptr[k][o] = 0; end
        errp[k] = 1'b0;
      end else begin
        for (int o = 0; o < 5; o++) nown[o] = own[k][o];
        for (int i = 0; i < 5; i++) if (eg[i] && t[k][i]) nown[lo[i]] = -1;
        nerr = 1'b0;
        for (int o = 0; o < 5; o++) begin
          if (own[k][o] < 0) begin
            done_b = 1'b0;
            for (int s = 0; s < 5; s++) begin
              cand = (ptr[k][o] + s) % 5;
              if (!done_b && v[k][cand] && h[k][cand] && lo[cand] < 0 && m_route(k, d[k][cand]) == o) begin
                nown[o]    = cand;
                last[k][o] = cand;
                ptr[k][o]  = (cand + 1) % 5;
                nerr       = nerr | m_oob(k, d[k][cand]);
                done_b     = 1'b1;
              end
            end
          end
        end
        for (int o = 0; o < 5; o++) own[k][o] = nown[o];
        errp[k] = nerr;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic push(input int k, input int i, input int dest, input int len);
    q_dest[k][i].push_back(dest);
    q_len[k][i].push_back(len);
  endtask

  task automatic run_single(input int k, input int i, input logic [3:0] dest, input int port,
                            input bit want_err, input string nm);
    push(k, i, int'(dest), 1);
    @(negedge clk);
    chk({nm, " no early grant"}, 32'(g[k][i]), 32'd0);
    @(negedge clk);
    chk({nm, " grant"}, 32'(g[k][i]), 32'd1);
    chk({nm, " out_valid"}, 32'(ov[k]), 32'd1 << port);
    chk({nm, " out_src"}, 32'(src[k][port]), 32'd0);
    chk({nm, " route_err"}, 32'(err[k]), 32'(want_err));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      v[k] = '0; h[k] = '0; t[k] = '0; d[k] = '0; rdy[k] = '1; exp_g[k] = '0;
      for (int o = 0; o < 5; o++) begin force_low[k][o] = 1'b0; own[k][o] = -1; end
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset dut%0d in_grant", k), 32'(g[k]), 32'd0);
      chk($sformatf("reset dut%0d out_valid", k), 32'(ov[k]), 32'd0);
      chk($sformatf("reset dut%0d out_src", k), 32'(src[k]), 32'd0);
      chk($sformatf("reset dut%0d route_err", k), 32'(err[k]), 32'd0);
    end
    rst_req = 1'b0;

    // XY sweep from input 0, then YX cases, then out-of-range destination.
    run_single(0, 0, 4'b1001, 0, 1'b0, "xy 1001->L");
    run_single(0, 0, 4'b0001, 2, 1'b0, "xy 0001->N");
    run_single(0, 0, 4'b1101, 4, 1'b0, "xy 1101->S");
    run_single(0, 0, 4'b0100, 1, 1'b0, "xy 0100->W");
    run_single(0, 0, 4'b0011, 3, 1'b0, "xy 0011->E");
    run_single(0, 0, 4'b0000, 1, 1'b0, "xy 0000->W");
    run_single(1, 0, 4'b0000, 2, 1'b0, "yx 0000->N");
    run_single(1, 0, 4'b1011, 3, 1'b0, "yx 1011->E");
    run_single(2, 0, 4'b1011, 0, 1'b1, "w3 1011->L");
    @(negedge clk);
    chk("w3 route_err one cycle", 32'(err[2]), 32'd0);

    // Contention: inputs 1 and 4 to E straight after a reset.
    rst_req = 1'b1;
    @(negedge clk);
    rst_req = 1'b0;
    push(0, 1, 4'b1011, 3);
    push(0, 4, 4'b1011, 3);
    @(negedge clk);
    chk("contend no early grant", 32'(g[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("contend in1 flit%0d", c), 32'(g[0]), 32'b00010);
      chk($sformatf("contend in1 src%0d", c), 32'(src[0][3]), 32'd1);
    end
    @(negedge clk);
    chk("contend bubble grant", 32'(g[0]), 32'd0);
    chk("contend bubble out_valid E", 32'(ov[0][3]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("contend in4 flit%0d", c), 32'(g[0]), 32'b10000);
      chk($sformatf("contend in4 src%0d", c), 32'(src[0][3]), 32'd4);
    end
    push(0, 1, 4'b1011, 3);
    push(0, 4, 4'b1011, 3);
    @(negedge clk);
    @(negedge clk);
    chk("contend repeat in1 wins", 32'(g[0]), 32'b00010);
    repeat (10) @(negedge clk);

    // Backpressure on E for three cycles in the middle of a 4-flit packet.
    push(0, 1, 4'b1011, 4);
    @(negedge clk);
    @(negedge clk);
    chk("bp first flit", 32'(g[0][1]), 32'd1);
    force_low[0][3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp stall%0d grant", c), 32'(g[0][1]), 32'd0);
      chk($sformatf("bp stall%0d out_valid", c), 32'(ov[0][3]), 32'd1);
    end
    force_low[0][3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp resume%0d grant", c), 32'(g[0][1]), 32'd1);
    end
    @(negedge clk);
    chk("bp released", 32'(ov[0][3]), 32'd0);

    // Reset in the middle of a W->E packet, then a fresh head from input 2.
    push(0, 1, 4'b1011, 6);
    repeat (3) @(negedge clk);
    chk("rst mid pkt flowing", 32'(g[0][1]), 32'd1);
    rst_req = 1'b1;
    @(negedge clk);
    chk("rst mid in_grant", 32'(g[0]), 32'd0);
    chk("rst mid out_valid", 32'(ov[0]), 32'd0);
    chk("rst mid out_src", 32'(src[0]), 32'd0);
    chk("rst mid route_err", 32'(err[0]), 32'd0);
    rst_req = 1'b0;
    push(0, 2, 4'b1011, 1);
    @(negedge clk);
    chk("post rst no early grant", 32'(g[0]), 32'd0);
    @(negedge clk);
    chk("post rst in2 grant", 32'(g[0]), 32'b00100);
    chk("post rst src E", 32'(src[0][3]), 32'd2);
    chk("post rst out_valid", 32'(ov[0]), 32'b01000);

    // Randomized traffic with bubbles, backpressure and rare resets.
    bubble_pct = 20;
    ready_pct  = 75;
    rand_mode  = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      rst_req = ($urandom_range(499) == 0);
    end
    rst_req = 1'b0;
    rand_mode = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
